// File: rtl/cast_vc_allocator.sv
// -----------------------------------------------------------------------------
// cast_vc_allocator
//
// Output-VC allocator for the cast (multicast) router. PN input stages share
// VN output virtual channels. Each input presents a candidate VC set that is
// granted atomically (all-or-nothing) and held until the input's tail flit
// leaves. At most one new grant per cycle, chosen round-robin.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous, active-high reset
//   reqVC      - [PN][VN] requested output-VC set per input
//   release_i  - [PN] tail-flit-fired pulse per input
//   selOutVC   - [PN][VN] granted VC set per input (zero when not held)
//   VCgranted  - [PN] high while the input holds its allocation
//   vc_busy_o  - [VN] per-VC ownership (OR of all held sets)
//
// Configuration macro: CAST_VCA_FAST_RELEASE_EN
//   defined   : VCs released at an edge are grantable at that same edge
//   undefined : released VCs become grantable one cycle later (shorter
//               combinational path from release_i to the grant logic)
// -----------------------------------------------------------------------------
`ifndef CN
`define CN 8
`endif

module cast_vc_allocator #(
  parameter int PN = 5,
  parameter int VN = `CN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PN-1:0][VN-1:0]  reqVC,
  input  logic [PN-1:0]          release_i,
  output logic [PN-1:0][VN-1:0]  selOutVC,
  output logic [PN-1:0]          VCgranted,
  output logic [VN-1:0]          vc_busy_o
);

  localparam int RRW = (PN > 1) ? $clog2(PN) : 1;

  logic [PN-1:0]          held_r, held_nxt_s;
  logic [PN-1:0][VN-1:0]  alloc_r, alloc_nxt_s;
  logic [VN-1:0]          busy_r, busy_nxt_s;
  logic [RRW-1:0]         rr_r, rr_nxt_s;

  logic [VN-1:0]          rel_set_s;
  logic [VN-1:0]          avail_s;
  logic [VN-1:0]          grant_set_s;
  logic [PN-1:0]          elig_s;
  logic                   grant_vld_s;
  logic [RRW-1:0]         grant_idx_s;

  // VCs being given back this cycle (only inputs that actually hold count)
  always_comb begin
    rel_set_s = '0;
    for (int i = 0; i < PN; i++) begin
      rel_set_s = rel_set_s | ((release_i[i] && held_r[i]) ? alloc_r[i] : {VN{1'b0}});
    end
  end

`ifdef CAST_VCA_FAST_RELEASE_EN
  // Released VCs are immediately reusable within the same cycle.
  assign avail_s = ~(busy_r & ~rel_set_s);
`else
  // Released VCs become reusable only once busy_r has been updated.
  assign avail_s = ~busy_r;
`endif

  // An input is eligible only if every VC it asks for is free: partial grants
  // would deadlock multicast packets, so an overlapping set waits whole.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < PN; i++) begin
      elig_s[i] = ~held_r[i] & (|reqVC[i]) & ~(|(reqVC[i] & ~avail_s));
    end
  end

  // Round-robin winner search starting at rr_r, wrapping modulo PN
  always_comb begin
    logic [RRW:0]   sum_v;
    logic [RRW-1:0] idx_v;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    sum_v       = '0;
    idx_v       = '0;
    for (int k = 0; k < PN; k++) begin
      sum_v = {1'b0, rr_r} + (RRW+1)'(k);
      if (sum_v >= (RRW+1)'(PN)) begin
        sum_v = sum_v - (RRW+1)'(PN);
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[RRW-1:0];
      if (!grant_vld_s && elig_s[idx_v]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = idx_v;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Grant set and pointer advance for the winner
  always_comb begin
    grant_set_s = '0;
    rr_nxt_s    = rr_r;
    if (grant_vld_s) begin
      grant_set_s = reqVC[grant_idx_s];
      rr_nxt_s    = (grant_idx_s == RRW'(PN-1)) ? {RRW{1'b0}} : grant_idx_s + RRW'(1);
    end else begin
      grant_set_s = '0;
      rr_nxt_s    = rr_r;
    end
  end

  // Per-input next state: release first, then the (never conflicting) grant;
  // a releasing input is still held at evaluation so it cannot be the winner.
  always_comb begin
    held_nxt_s  = held_r;
    alloc_nxt_s = alloc_r;
    for (int i = 0; i < PN; i++) begin
      if (release_i[i] && held_r[i]) begin
        held_nxt_s[i]  = 1'b0;
        alloc_nxt_s[i] = '0;
      end else begin
        held_nxt_s[i]  = held_r[i];
        alloc_nxt_s[i] = alloc_r[i];
      end
    end
    if (grant_vld_s) begin
      held_nxt_s[grant_idx_s]  = 1'b1;
      alloc_nxt_s[grant_idx_s] = reqVC[grant_idx_s];
    end else begin
      held_nxt_s = held_nxt_s;
    end
    busy_nxt_s = (busy_r & ~rel_set_s) | grant_set_s;
  end

  // State registers; reset drops every allocation and any pending release
  always_ff @(posedge clk) begin
    if (rst) begin
      held_r  <= '0;
      alloc_r <= '0;
      busy_r  <= '0;
      rr_r    <= '0;
    end else begin
      held_r  <= held_nxt_s;
      alloc_r <= alloc_nxt_s;
      busy_r  <= busy_nxt_s;
      rr_r    <= rr_nxt_s;
    end
  end

  assign selOutVC  = alloc_r;
  assign VCgranted = held_r;
  assign vc_busy_o = busy_r;

endmodule

// File: tb/tb_cast_vc_allocator.sv
// -----------------------------------------------------------------------------
// tb_cast_vc_allocator
//
// Table-driven bench for cast_vc_allocator (PN=5, VN=8). Each record gives the
// inputs for one clock edge and the outputs expected just after it. Vectors
// are hand-computed; the FAST_RELEASE build swaps in its own expected values
// where the release-to-regrant gap differs. A per-cycle check confirms held
// sets are disjoint and vc_busy_o is their OR. A short hand-written sequence
// at the end exercises grant and release latency with a bounded wait.
// -----------------------------------------------------------------------------
module tb_cast_vc_allocator;

  localparam int PN = 5;
  localparam int VN = 8;

  logic                  clk;
  logic                  rst;
  logic [PN-1:0][VN-1:0] reqVC;
  logic [PN-1:0]         release_i;
  logic [PN-1:0][VN-1:0] selOutVC;
  logic [PN-1:0]         VCgranted;
  logic [VN-1:0]         vc_busy_o;

  int tests;
  int failed;

  typedef struct {
    logic        rst;
    logic [39:0] req;
    logic [4:0]  rel;
    logic [4:0]  g;
    logic [39:0] sel;
    logic [7:0]  busy;
  } vec_t;

  vec_t vecs[$];

  cast_vc_allocator #(.PN(PN), .VN(VN)) dut (
    .clk       (clk),
    .rst       (rst),
    .reqVC     (reqVC),
    .release_i (release_i),
    .selOutVC  (selOutVC),
    .VCgranted (VCgranted),
    .vc_busy_o (vc_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [39:0] req, input logic [4:0] rel,
                     input logic [4:0] g, input logic [39:0] sel, input logic [7:0] busy);
    vec_t v;
    v.rst = r; v.req = req; v.rel = rel; v.g = g; v.sel = sel; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int n, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic check_inv(input int n);
    logic [VN-1:0] acc;
    logic          ok;
    acc = '0;
    ok  = 1'b1;
    for (int i = 0; i < PN; i++) begin
      if (VCgranted[i]) begin
        if ((acc & selOutVC[i]) != 8'h00) ok = 1'b0;
        acc = acc | selOutVC[i];
      end else if (selOutVC[i] != 8'h00) begin
        ok = 1'b0;
      end
    end
    tests++;
    if (!ok || acc !== vc_busy_o) begin
      failed++;
      $display("FAIL invariant step %0d: busy %h, OR of held sets %h, disjoint %0d",
               n, vc_busy_o, acc, ok);
    end
  endtask

  initial begin
    int waited;
    tests     = 0;
    failed    = 0;
    rst       = 1'b1;
    reqVC     = '0;
    release_i = '0;

    // req/sel packing: {in4, in3, in2, in1, in0}, one byte each
    add(1'b1, 40'h00_00_00_00_00, 5'h00, 5'h00, 40'h00_00_00_00_00, 8'h00); // v0 reset
    add(1'b0, 40'h00_00_00_00_03, 5'h00, 5'h01, 40'h00_00_00_00_03, 8'h03); // v1 in0 gets 0011
    add(1'b0, 40'h00_00_04_04_03, 5'h00, 5'h03, 40'h00_00_00_04_03, 8'h07); // v2 in1 wins 0100
    add(1'b0, 40'h00_00_04_04_03, 5'h00, 5'h03, 40'h00_00_00_04_03, 8'h07); // v3 in2 waits
`ifdef CAST_VCA_FAST_RELEASE_EN
    add(1'b0, 40'h00_00_04_00_03, 5'h02, 5'h05, 40'h00_00_04_00_03, 8'h07); // v4 release1, in2 same edge
`else
    add(1'b0, 40'h00_00_04_00_03, 5'h02, 5'h01, 40'h00_00_00_00_03, 8'h03); // v4 release1 only
`endif
    add(1'b0, 40'h00_00_04_00_03, 5'h00, 5'h05, 40'h00_00_04_00_03, 8'h07); // v5 in2 held
    add(1'b0, 40'h00_0A_04_00_03, 5'h00, 5'h05, 40'h00_00_04_00_03, 8'h07); // v6 in3 1010 blocked
    add(1'b0, 40'h00_0A_04_00_F0, 5'h02, 5'h05, 40'h00_00_04_00_03, 8'h07); // v7 stray rel, req0 change
`ifdef CAST_VCA_FAST_RELEASE_EN
    add(1'b0, 40'h00_0A_04_00_00, 5'h01, 5'h0C, 40'h00_0A_04_00_00, 8'h0E); // v8 release0, in3 same edge
`else
    add(1'b0, 40'h00_0A_04_00_00, 5'h01, 5'h04, 40'h00_00_04_00_00, 8'h04); // v8 release0 only
`endif
    add(1'b0, 40'h00_0A_04_00_00, 5'h00, 5'h0C, 40'h00_0A_04_00_00, 8'h0E); // v9 in3 whole set
    add(1'b0, 40'h00_00_00_00_00, 5'h0C, 5'h00, 40'h00_00_00_00_00, 8'h00); // v10 release 2,3
    add(1'b0, 40'h00_00_01_00_00, 5'h00, 5'h04, 40'h00_00_01_00_00, 8'h01); // v11 in2, rr->3
    add(1'b0, 40'h00_00_01_00_00, 5'h04, 5'h00, 40'h00_00_00_00_00, 8'h00); // v12 no regrant on release
    add(1'b0, 40'h10_08_04_02_01, 5'h00, 5'h08, 40'h00_08_00_00_00, 8'h08); // v13 order 3
    add(1'b0, 40'h10_08_04_02_01, 5'h00, 5'h18, 40'h10_08_00_00_00, 8'h18); // v14 4
    add(1'b0, 40'h10_08_04_02_01, 5'h00, 5'h19, 40'h10_08_00_00_01, 8'h19); // v15 0
    add(1'b0, 40'h10_08_04_02_01, 5'h00, 5'h1B, 40'h10_08_00_02_01, 8'h1B); // v16 1
    add(1'b0, 40'h10_08_04_02_01, 5'h00, 5'h1F, 40'h10_08_04_02_01, 8'h1F); // v17 2
    add(1'b0, 40'h10_08_04_02_01, 5'h00, 5'h1F, 40'h10_08_04_02_01, 8'h1F); // v18 stable, rr=3
    add(1'b0, 40'h10_08_04_00_00, 5'h03, 5'h1C, 40'h10_08_04_00_00, 8'h1C); // v19 three held
    add(1'b1, 40'h10_08_04_00_00, 5'h04, 5'h00, 40'h00_00_00_00_00, 8'h00); // v20 reset mid-packet
    add(1'b0, 40'h10_08_04_00_00, 5'h00, 5'h04, 40'h00_00_04_00_00, 8'h04); // v21 rr=0 -> in2 first
    add(1'b0, 40'h10_08_04_00_00, 5'h00, 5'h0C, 40'h00_08_04_00_00, 8'h0C); // v22 in3
    add(1'b0, 40'h10_08_04_00_00, 5'h00, 5'h1C, 40'h10_08_04_00_00, 8'h1C); // v23 in4, rr->0

    for (int n = 0; n < vecs.size(); n++) begin
      rst       = vecs[n].rst;
      reqVC     = vecs[n].req;
      release_i = vecs[n].rel;
      @(posedge clk);
      #1;
      release_i = '0;
      check("VCgranted", n, 40'(VCgranted), 40'(vecs[n].g));
      check("selOutVC",  n, selOutVC,       vecs[n].sel);
      check("vc_busy_o", n, 40'(vc_busy_o), 40'(vecs[n].busy));
      check_inv(n);
    end

    // Grant latency with a bounded wait: in1 asks for a free VC, rr=0
    rst    = 1'b0;
    reqVC  = 40'h00_00_00_20_00;
    waited = 0;
    while (!VCgranted[1] && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("grant_wait_cycles", 100, 40'(waited), 40'd1);
    check("sel1_after_grant",  100, 40'(selOutVC[1]), 40'h20);
    check("busy_after_grant",  100, 40'(vc_busy_o), 40'h3C);
    check_inv(100);

    // Release latency: pulse one cycle, VC bit and level drop next cycle
    reqVC     = '0;
    release_i = 5'h02;
    @(posedge clk);
    #1;
    release_i = '0;
    check("granted_after_release", 101, 40'(VCgranted), 40'h1C);
    check("busy_after_release",    101, 40'(vc_busy_o), 40'h1C);
    check("sel1_after_release",    101, 40'(selOutVC[1]), 40'h00);
    check_inv(101);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
